// File: rtl/iob_addsub_pkg.sv
// Shared definitions for every client of the iob_addsub datapath.
// Op encodings live here so requesters and arbiters agree on them.
package iob_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_addsub.sv
// Combinational signed add/subtract over a sign-extended DATA_W+1 bit sum.
// Carry and overflow are taken from the top two sum bits.
module iob_addsub
  import iob_addsub_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  addsub_op_e        op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o,
  output logic              overflow_o
);

  logic              sub;
  logic [DATA_W:0]   a_ext;
  logic [DATA_W:0]   b_ext;
  logic [DATA_W:0]   sum;

  assign sub   = (op_i == OP_SUB);
  assign a_ext = {a_i[DATA_W-1], a_i};
  // Subtract as A + ~B + 1 on the extended operands.
  assign b_ext = {(DATA_W+1){sub}} ^ {b_i[DATA_W-1], b_i};
  assign sum   = a_ext + b_ext + {{DATA_W{1'b0}}, sub};

  assign res_o      = sum[DATA_W-1:0];
  assign carry_o    = sum[DATA_W];
  assign overflow_o = sum[DATA_W] ^ sum[DATA_W-1];

endmodule

// File: rtl/iob_addsub_arb.sv
// Round-robin arbiter sharing one iob_addsub among N_REQ requesters,
// with a one-entry registered response slot (latency 1, drain+accept in one cycle).
module iob_addsub_arb
  import iob_addsub_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int N_REQ  = 4,
  localparam int ID_W   = id_width(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_op_a_i,
  input  logic [N_REQ*DATA_W-1:0] req_op_b_i,
  input  logic [N_REQ-1:0]        req_op_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_res_o,
  output logic                    rsp_carry_o,
  output logic                    rsp_overflow_o
);

  // First valid bit at or above ptr, wrapping modulo N_REQ.
  function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] vld,
                                                input logic [ID_W-1:0]  ptr);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [ID_W-1:0]  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && vld[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  slot_state_e state_q, state_d;
  logic [ID_W-1:0]                ptr_q;
  logic [N_REQ-1:0]               gnt;
  logic [ID_W-1:0]                gnt_idx;
  logic                           slot_free;
  logic                           accept;
  logic [N_REQ-1:0][DATA_W-1:0]   op_a;
  logic [N_REQ-1:0][DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]              alu_res;
  logic                           alu_carry;
  logic                           alu_ovf;

  assign op_a = req_op_a_i;
  assign op_b = req_op_b_i;

  assign slot_free   = (state_q == SLOT_EMPTY) || rsp_ready_i;
  assign gnt         = rr_grant(req_valid_i & {N_REQ{slot_free}}, ptr_q);
  // Grants are masked while reset is held so nothing slips into the slot.
  assign req_ready_o = arst_n_i ? gnt : '0;
  assign accept      = |req_ready_o;

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++)
      if (gnt[k]) gnt_idx = ID_W'(k);
  end

  iob_addsub #(.DATA_W(DATA_W)) u_addsub (
    .a_i        (op_a[gnt_idx]),
    .b_i        (op_b[gnt_idx]),
    .op_i       (addsub_op_e'(req_op_i[gnt_idx])),
    .res_o      (alu_res),
    .carry_o    (alu_carry),
    .overflow_o (alu_ovf)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= SLOT_EMPTY;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (!accept && rsp_ready_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  assign rsp_valid_o = (state_q == SLOT_FULL);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ptr_q          <= '0;
      rsp_id_o       <= '0;
      rsp_res_o      <= '0;
      rsp_carry_o    <= 1'b0;
      rsp_overflow_o <= 1'b0;
    end else if (accept) begin
      ptr_q          <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      rsp_id_o       <= gnt_idx;
      rsp_res_o      <= alu_res;
      rsp_carry_o    <= alu_carry;
      rsp_overflow_o <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_iob_addsub_arb.sv
// Scoreboard bench for iob_addsub_arb: a queue-based reference model predicts
// grants and responses; a separate monitor checks the response port.
module tb_iob_addsub_arb;

  localparam int DW = 32;
  localparam int NR = 4;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] res;
    logic          c;
    logic          v;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  arst_n_i;
  logic [NR-1:0]         req_valid_i;
  logic [NR-1:0]         req_ready_o;
  logic [NR-1:0][DW-1:0] op_a;
  logic [NR-1:0][DW-1:0] op_b;
  logic [NR-1:0]         req_op_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [1:0]            rsp_id_o;
  logic [DW-1:0]         rsp_res_o;
  logic                  rsp_carry_o;
  logic                  rsp_overflow_o;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   m_ptr;
  bit   m_full;
  int   m_gnt;

  iob_addsub_arb #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_a_i     (op_a),
    .req_op_b_i     (op_b),
    .req_op_i       (req_op_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_id_o       (rsp_id_o),
    .rsp_res_o      (rsp_res_o),
    .rsp_carry_o    (rsp_carry_o),
    .rsp_overflow_o (rsp_overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact signed arithmetic; carry is the sign of the true result.
  function automatic exp_t model(input int k, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic op);
    exp_t   e;
    longint sa, sb, r, lim;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    r     = op ? sa - sb : sa + sb;
    lim   = longint'(1) <<< (DW-1);
    e.id  = 2'(k);
    e.res = r[DW-1:0];
    e.c   = (r < 0);
    e.v   = (r >= lim) || (r < -lim);
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Model evaluates at the falling edge what the next rising edge will do.
  task automatic cycle();
    logic [NR-1:0] er;
    int idx;
    @(negedge clk);
    m_gnt = -1;
    if (!m_full || rsp_ready_i)
      for (int i = 0; i < NR; i++) begin
        idx = (m_ptr + i) % NR;
        if (m_gnt < 0 && req_valid_i[idx]) m_gnt = idx;
      end
    er = '0;
    if (m_gnt >= 0) er[m_gnt] = 1'b1;
    chk("req_ready", req_ready_o, er);
    chk("rsp_valid", rsp_valid_o, m_full);
    if (m_gnt >= 0) begin
      exp_q.push_back(model(m_gnt, op_a[m_gnt], op_b[m_gnt], req_op_i[m_gnt]));
      m_ptr  = (m_gnt + 1) % NR;
      m_full = 1'b1;
    end else if (rsp_ready_i) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_all();
    for (int k = 0; k < NR; k++) begin
      op_a[k] = rnd_operand();
      op_b[k] = rnd_operand();
    end
    req_op_i = 4'($urandom);
  endtask

  // Monitor: any presented response must match the oldest expected one.
  always @(negedge clk) begin
    if (arst_n_i === 1'b1 && rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        chk("rsp_id",  rsp_id_o,       exp_q[0].id);
        chk("rsp_res", rsp_res_o,      exp_q[0].res);
        chk("rsp_c",   rsp_carry_o,    exp_q[0].c);
        chk("rsp_v",   rsp_overflow_o, exp_q[0].v);
        if (rsp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 4'b0);
    chk({tag, "_rvalid"}, rsp_valid_o, 1'b0);
    chk({tag, "_rid"}, rsp_id_o, 2'b0);
    chk({tag, "_rres"}, rsp_res_o, 32'b0);
    chk({tag, "_rc"}, rsp_carry_o, 1'b0);
    chk({tag, "_rv"}, rsp_overflow_o, 1'b0);
  endtask

  initial begin
    arst_n_i    = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    randomize_all();
    m_ptr  = 0;
    m_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid_i = 4'hF;
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    arst_n_i    = 1'b1;
    req_valid_i = 4'b1010;
    rsp_ready_i = 1'b1;
    cycle();

    // Single add on requester 1
    req_valid_i = 4'b0010;
    op_a[1] = 32'd5; op_b[1] = 32'd3; req_op_i[1] = 1'b0;
    cycle();
    req_valid_i = '0;
    cycle();

    // Subtract overflow on requester 2
    req_valid_i = 4'b0100;
    op_a[2] = 32'h8000_0000; op_b[2] = 32'd1; req_op_i[2] = 1'b1;
    cycle();
    req_valid_i = '0;
    cycle();

    // Fairness with everyone valid
    req_valid_i = 4'hF;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (m_gnt >= 0) begin
        op_a[m_gnt] = rnd_operand();
        op_b[m_gnt] = rnd_operand();
      end
    end

    // Backpressure: fill slot, hold it, then drain and accept together
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    cycle();
    req_valid_i = 4'b1000;
    repeat (3) cycle();
    rsp_ready_i = 1'b1;
    cycle();
    req_valid_i = '0;
    cycle();

    // Drop-out while blocked
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    cycle();
    req_valid_i = 4'b0001;
    cycle();
    req_valid_i = '0;
    cycle();
    rsp_ready_i = 1'b1;
    cycle();
    req_valid_i = 4'hF;
    cycle();
    req_valid_i = '0;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      req_valid_i = 4'($urandom);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      randomize_all();
      cycle();
    end

    // Reset mid-response
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    cycle();
    req_valid_i = '0;
    cycle();
    #2;
    arst_n_i    = 1'b0;
    req_valid_i = 4'hF;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    @(posedge clk);
    #1;
    arst_n_i    = 1'b1;
    rsp_ready_i = 1'b1;
    cycle();
    req_valid_i = '0;
    repeat (2) cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_addsub_arb.md
IOB_ADDSUB_ARB -- requirements
Module: iob_addsub_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..16); ID_W = max(1, clog2(N_REQ)).
REQ-003 clk_i  input  1  single clock; all state on its rising edge.
REQ-004 arst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 req_valid_i  input  N_REQ  per-requester request valid.
REQ-006 req_ready_o  output  N_REQ  per-requester accept (grant), at most one bit set.
REQ-007 req_op_a_i  input  N_REQ*DATA_W  operand A; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 req_op_b_i  input  N_REQ*DATA_W  operand B, same packing.
REQ-009 req_op_i  input  N_REQ  operation select: 0 = add (A+B), 1 = subtract (A-B).
REQ-010 rsp_valid_o  output  1  response slot holds a result.
REQ-011 rsp_ready_i  input  1  consumer accepts response.
REQ-012 rsp_id_o  output  ID_W  index of the requester that owns the result.
REQ-013 rsp_res_o  output  DATA_W  result, low DATA_W bits.
REQ-014 rsp_carry_o  output  1  bit DATA_W of the sign-extended (DATA_W+1)-bit sum.
REQ-015 rsp_overflow_o  output  1  signed overflow: XOR of sum bits DATA_W and DATA_W-1.

Function
REQ-016 The block SHALL share one add/sub datapath among N_REQ requesters, with a one-entry registered response slot.
REQ-017 Slot state SHALL be EMPTY or FULL; EMPTY->FULL on accept; FULL->EMPTY on rsp_ready_i with no accept; FULL->FULL on drain plus accept in the same cycle.
REQ-018 slot_free = EMPTY, or FULL with rsp_ready_i high; no request SHALL be accepted when slot_free is low.
REQ-019 req_ready_o[k] SHALL be combinational: high only if slot_free, req_valid_i[k], and k is the first valid requester scanning from the priority pointer upward modulo N_REQ.
REQ-020 A request SHALL be accepted in the cycle req_valid_i[k] and req_ready_o[k] are both high; requesters hold valid and operands stable until accepted.
REQ-021 The priority pointer SHALL reset to 0 and, on accept by k, become (k+1) mod N_REQ; with no accept it SHALL hold.
REQ-022 The result of an accepted request SHALL appear on rsp_* in the next cycle (latency 1) and stay stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-023 Arithmetic: sum = {A[msb],A} + ({op}^{B[msb],B}) + op over DATA_W+1 bits; res, carry and overflow SHALL be taken from sum per REQ-013..015.
REQ-024 With all requesters continuously valid and rsp_ready_i high, one request SHALL be accepted every cycle in strict round-robin order.
REQ-025 A requester that drops valid before being granted SHALL lose nothing; the pointer is unaffected.

Reset
REQ-026 On arst_n_i low, the block SHALL immediately clear slot to EMPTY, pointer to 0, rsp_valid_o, rsp_id_o, rsp_res_o, rsp_carry_o and rsp_overflow_o to 0; req_ready_o SHALL be 0 during reset.
REQ-027 A response pending when reset asserts SHALL be discarded; no request SHALL be accepted while reset is asserted.
REQ-028 Reset release SHALL be synchronised externally; the first accept can occur on the first clock edge after release.

Structure
REQ-029 The op encodings (OP_ADD=0, OP_SUB=1) SHALL reside in the shared addsub include/package, reused by all addsub clients.
REQ-030 The datapath SHALL be one instance of the existing iob_addsub module, fed by the granted requester's operands through a mux; the arbiter is the only new logic.
REQ-031 The round-robin grant SHALL be a single combinational function in this module; no further sub-modules.

Verification
REQ-032 Reset: arst_n_i low mid-response -> rsp_valid_o=0, req_ready_o=0, all rsp_* zero; after release, first grant goes to lowest valid index from 0.
REQ-033 Single add: req 1 valid, A=5, B=3, op=0, rsp_ready_i=1 -> req_ready_o=4'b0010 same cycle; next cycle rsp_valid_o=1, id=1, res=8, carry=0, overflow=0.
REQ-034 Subtract overflow: req 2, A=0x80000000, B=1, op=1 -> res=0x7FFFFFFF, carry=1, overflow=1, id=2.
REQ-035 Fairness: all four valid, rsp_ready_i=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3 and ids follow 1 cycle later.
REQ-036 Backpressure: slot FULL, rsp_ready_i=0 for 3 cycles with req 3 valid -> req_ready_o=0, rsp_* stable; raise rsp_ready_i -> req 3 granted that cycle, its result next cycle with no bubble.
REQ-037 Drop-out: req 0 valid one cycle while slot blocked, then deasserted -> no grant to 0, pointer unchanged.
